// File: rtl/gb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : gb_pkg                                                         |
// | Purpose   : Shared ghostbus host defaults and width helpers                |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package gb_pkg;

  localparam int GB_AW      = 24;
  localparam int GB_DW      = 32;
  localparam int GB_RD_LAT  = 2;
  localparam int GB_FIFO_AW = 2;

  // Credits span 0..2**fifo_aw inclusive, so they need one bit above the pointer.
  function automatic int gb_credit_w(input int fifo_aw);
    return fifo_aw + 1;
  endfunction

endpackage : gb_pkg
`default_nettype wire

// File: rtl/gb_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : gb_rsp_fifo                                                    |
// | Purpose   : Synchronous first-word-fall-through read response FIFO         |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module gb_rsp_fifo #(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_full;

  assign o_valid  = (r_count != '0);
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop = i_pop & o_valid;
  assign o_rdata  = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally; occupancy is one bit wider to separate full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The credit scheme upstream must never let a push land on a full FIFO.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full))
    else $error("gb_rsp_fifo: push while full");

endmodule : gb_rsp_fifo
`default_nettype wire

// File: rtl/gb_host_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : gb_host_master                                                 |
// | Purpose   : Ghostbus initiator; request stream in, pipelined reads out     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module gb_host_master
  import gb_pkg::*;
#(
  parameter int AW      = GB_AW,
  parameter int DW      = GB_DW,
  parameter int RD_LAT  = GB_RD_LAT,
  parameter int FIFO_AW = GB_FIFO_AW
) (
  input  logic          gb_clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  input  logic [DW-1:0] gb_din,
  output logic          gb_we
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = gb_credit_w(FIFO_AW);

  // Every read in flight must have a FIFO slot reserved, so depth must cover latency.
  generate
    if (RD_LAT < 1) begin : g_bad_rd_lat
      $error("gb_host_master: RD_LAT must be at least 1");
    end
    if (DEPTH < RD_LAT + 1) begin : g_bad_fifo_depth
      $error("gb_host_master: 2**FIFO_AW must be >= RD_LAT+1");
    end
  endgenerate

  logic              r_req_ready;
  logic [CW-1:0]     r_credit;
  logic [CW-1:0]     w_credit_next;
  logic [RD_LAT-1:0] r_read_pipe;
  logic [AW-1:0]     r_gb_addr;
  logic [DW-1:0]     r_gb_dout;
  logic              r_gb_we;
  logic              w_accept;
  logic              w_rd_accept;
  logic              w_push;
  logic              w_pop;

  assign w_accept    = req_valid & r_req_ready;
  assign w_rd_accept = w_accept & ~req_we;
  assign w_push      = r_read_pipe[RD_LAT-1];
  assign w_pop       = rsp_valid & rsp_ready;

  assign req_ready = r_req_ready;
  assign gb_addr   = r_gb_addr;
  assign gb_dout   = r_gb_dout;
  assign gb_we     = r_gb_we;
  assign busy      = (|r_read_pipe) | rsp_valid;

  // Next credit: reads take a slot on accept and return it on pop; both together cancel.
  always_comb begin
    w_credit_next = r_credit;
    if (w_rd_accept && !w_pop)      w_credit_next = r_credit + 1'b1;
    else if (!w_rd_accept && w_pop) w_credit_next = r_credit - 1'b1;
  end

  // Credit counter and registered ready, so ready never sees req_valid combinationally.
  always_ff @(posedge gb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit    <= '0;
      r_req_ready <= 1'b0;
    end else begin
      r_credit    <= w_credit_next;
      r_req_ready <= (w_credit_next < CW'(DEPTH));
    end
  end

  // Launch register: address/data hold between accepts, the write strobe lasts one cycle.
  always_ff @(posedge gb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gb_addr <= '0;
      r_gb_dout <= '0;
      r_gb_we   <= 1'b0;
    end else begin
      r_gb_we <= w_accept & req_we;
      if (w_accept) begin
        r_gb_addr <= req_addr;
        r_gb_dout <= req_wdata;
      end
    end
  end

  // Read tag pipe: its last stage marks the edge at which gb_din is valid for a read.
  always_ff @(posedge gb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_pipe <= '0;
    end else begin
      r_read_pipe[0] <= w_rd_accept;
      for (int i = 1; i < RD_LAT; i++) r_read_pipe[i] <= r_read_pipe[i-1];
    end
  end

  gb_rsp_fifo #(
    .DW (DW),
    .AW (FIFO_AW)
  ) u_rsp_fifo (
    .clk     (gb_clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (gb_din),
    .i_pop   (rsp_ready),
    .o_valid (rsp_valid),
    .o_rdata (rsp_rdata)
  );

endmodule : gb_host_master
`default_nettype wire

// File: tb/tb_gb_host_master.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_gb_host_master                                              |
// | Purpose   : Scoreboard bench for gb_host_master with a registered RAM      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_gb_host_master;

  localparam int AW = 24;
  localparam int DW = 32;

  logic          gb_clk = 1'b0;
  logic          rst_n  = 1'b1;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_dout;
  logic [DW-1:0] gb_din;
  logic          gb_we;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int stall_cycles = 0;

  logic [DW-1:0]    exp_rd[$];
  logic [AW+DW-1:0] exp_wr[$];
  int               rsp_cyc[$];

  always #5 gb_clk = ~gb_clk;

  always @(posedge gb_clk) cyc = cyc + 1;

  gb_host_master #(
    .AW      (AW),
    .DW      (DW),
    .RD_LAT  (2),
    .FIFO_AW (2)
  ) dut (
    .gb_clk    (gb_clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .gb_addr   (gb_addr),
    .gb_dout   (gb_dout),
    .gb_din    (gb_din),
    .gb_we     (gb_we)
  );

  // Registered ghostbus RAM: one cycle to register address, one to return data.
  logic [DW-1:0] ram [0:511];
  initial begin
    for (int i = 0; i < 512; i++) ram[i] = '0;
    for (int i = 0; i < 4; i++) begin
      ram[i]        = 32'h1111_0000 + i;
      ram[32'h20+i] = 32'h2222_0000 + i;
    end
    ram[4]      = 32'hdead_beef;
    ram[9'h100] = 32'h0000_00cc;
    forever begin
      @(posedge gb_clk);
      if (gb_we) ram[gb_addr[8:0]] <= gb_dout;
      gb_din <= ram[gb_addr[8:0]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic step();
    @(posedge gb_clk);
    #1;
  endtask

  // Present one request and hold it until accepted; leaves req_valid high.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic want_rsp, input logic [DW-1:0] rsp_data);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    while (!req_ready && w < 50) begin
      step();
      w++;
      stall_cycles++;
    end
    if (!req_ready) begin
      fail_bound("issue_ready");
    end else begin
      if (we)            exp_wr.push_back({addr, data});
      else if (want_rsp) exp_rd.push_back(rsp_data);
      step();
    end
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((exp_rd.size() != 0 || busy) && w < 40) begin
      step();
      w++;
    end
    if (exp_rd.size() != 0) fail_bound(name);
  endtask

  // Scoreboard monitor: compares every handshaken response and every bus write.
  always @(negedge gb_clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_cyc.push_back(cyc);
      if (exp_rd.size() == 0) check("rsp_unexpected", {32'h0, rsp_rdata}, 64'hffff_ffff_ffff_ffff);
      else check("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, exp_rd.pop_front()});
    end
    if (rst_n && gb_we) begin
      if (exp_wr.size() == 0) check("wr_unexpected", {8'h0, gb_addr, gb_dout}, 64'hffff_ffff_ffff_ffff);
      else check("wr_addr_data", {8'h0, gb_addr, gb_dout}, {8'h0, exp_wr.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int n_seen;
    int span;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_gb_addr",   64'(gb_addr),   64'h0);
    check("rst_gb_dout",   64'(gb_dout),   64'h0);
    check("rst_gb_we",     64'(gb_we),     64'h0);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_busy",      64'(busy),      64'h0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    check("ready_after_rst", 64'(req_ready), 64'h1);

    // 1: posted write
    issue(1'b1, 24'h000010, 32'hcece_face, 1'b0, 32'h0);
    req_valid = 1'b0;
    check("t1_gb_we_high", 64'(gb_we),   64'h1);
    check("t1_gb_addr",    64'(gb_addr), 64'h10);
    check("t1_gb_dout",    64'(gb_dout), 64'hcece_face);
    step();
    check("t1_gb_we_low",  64'(gb_we),   64'h0);
    check("t1_addr_hold",  64'(gb_addr), 64'h10);
    repeat (3) step();
    check("t1_no_rsp",     64'(rsp_valid), 64'h0);
    check("t1_not_busy",   64'(busy),      64'h0);

    // 2: single read latency
    issue(1'b0, 24'h000100, 32'h0, 1'b1, 32'h0000_00cc);
    req_valid = 1'b0;
    check("t2_valid_c1", 64'(rsp_valid), 64'h0);
    check("t2_busy",     64'(busy),      64'h1);
    step();
    check("t2_valid_c2", 64'(rsp_valid), 64'h0);
    step();
    check("t2_valid_c3", 64'(rsp_valid), 64'h1);
    drain("t2_drain");

    // 3: back-to-back reads at full throughput
    stall_cycles = 0;
    rsp_cyc.delete();
    for (int i = 0; i < 4; i++) issue(1'b0, AW'(i), 32'h0, 1'b1, 32'h1111_0000 + i);
    req_valid = 1'b0;
    drain("t3_drain");
    check("t3_no_stall", 64'(stall_cycles), 64'h0);
    check("t3_rsp_count", 64'(rsp_cyc.size()), 64'h4);
    span = (rsp_cyc.size() == 4) ? rsp_cyc[3] - rsp_cyc[0] : -1;
    check("t3_rsp_consecutive", 64'(span), 64'h3);

    // 4: credit limit with the consumer stalled
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int n = 0; n < 8; n++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = AW'(32'h20 + n);
      if (req_ready) begin
        exp_rd.push_back(32'h2222_0000 + n);
        n_acc++;
      end
      step();
    end
    req_valid = 1'b0;
    check("t4_accepted",     64'(n_acc),     64'h4);
    check("t4_ready_low",    64'(req_ready), 64'h0);
    check("t4_fifo_valid",   64'(rsp_valid), 64'h1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t4_ready_after_pop", 64'(req_ready), 64'h1);
    step();
    check("t4_ready_stays",     64'(req_ready), 64'h1);
    rsp_ready = 1'b1;
    drain("t4_drain");

    // 5: read right behind a write to the same address
    issue(1'b1, 24'h000004, 32'h0000_00a5, 1'b0, 32'h0);
    issue(1'b0, 24'h000004, 32'h0, 1'b1, 32'h0000_00a5);
    req_valid = 1'b0;
    drain("t5_drain");

    // 6: reset with reads in flight
    issue(1'b0, 24'h000000, 32'h0, 1'b0, 32'h0);
    issue(1'b0, 24'h000001, 32'h0, 1'b0, 32'h0);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_gb_addr",   64'(gb_addr),   64'h0);
    check("t6_gb_dout",   64'(gb_dout),   64'h0);
    check("t6_gb_we",     64'(gb_we),     64'h0);
    check("t6_req_ready", 64'(req_ready), 64'h0);
    check("t6_rsp_valid", 64'(rsp_valid), 64'h0);
    check("t6_busy",      64'(busy),      64'h0);
    repeat (2) step();
    rst_n = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) n_seen++;
      step();
    end
    check("t6_no_stale_rsp", 64'(n_seen), 64'h0);

    check("end_rd_queue_empty", 64'(exp_rd.size()), 64'h0);
    check("end_wr_queue_empty", 64'(exp_wr.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_gb_host_master
`default_nettype wire
